avalon_multi_timer: RTL and testbench

- Parametrised, multi-channel interval timer on a memory-mapped slave (chipselect/write_n/address/writedata, registered readdata).
- Next generation of the single-channel 16-bit-bus timer. Provides NUM_CH independent down-counters of CNT_W bits behind a 32-bit bus.
- Adds per-channel interrupt vector, combined irq, and an optional clock prescaler.
- Sits beside the CPU as the system tick and event timer source.

---
 rtl/avalon_multi_timer.sv | 178 +++++++++++++++++
 tb/tb_avalon_multi_timer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer on a memory-mapped slave: NUM_CH down-counters of CNT_W bits.
// Define TIMER_PRESCALER_EN to add an 8-bit per-channel clock prescaler in CONTROL[15:8].
module avalon_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(NUM_CH)+1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_CH-1:0]         irq_vec,
  output logic                      irq
);

  localparam int AW = $clog2(NUM_CH) + 2;
  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

  typedef enum logic [1:0] {
    OFF_STATUS  = 2'd0,
    OFF_CONTROL = 2'd1,
    OFF_PERIOD  = 2'd2,
    OFF_SNAP    = 2'd3
  } offset_e;

  logic [AW-1:0]           chSel;
  offset_e                 offset;
  logic                    wrEn;
  logic [NUM_CH-1:0][31:0] chRd;
  logic [31:0]             readdata_q;
  logic [31:0]             readdata_d;

  assign chSel  = address >> 2;
  assign offset = offset_e'(address[1:0]);
  assign wrEn   = chipselect & ~write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             to_q, to_d;
    logic             run_q, run_d;
    logic             zeroDly_q;
    logic             forceReload_q;
    logic             chWr, wrStatus, wrCtrl, wrPeriod, wrSnap;
    logic             isZero, toEvent, tick, startCmd, stopCmd;
    logic [7:0]       prescale;
    logic [31:0]      rdVal;

    assign chWr     = wrEn & (chSel == AW'(g));
    assign wrStatus = chWr & (offset == OFF_STATUS);
    assign wrCtrl   = chWr & (offset == OFF_CONTROL);
    assign wrPeriod = chWr & (offset == OFF_PERIOD);
    assign wrSnap   = chWr & (offset == OFF_SNAP);
    assign startCmd = wrCtrl & writedata[2];
    assign stopCmd  = wrCtrl & writedata[3];
    assign isZero   = (cnt_q == '0);
    assign toEvent  = isZero & ~zeroDly_q;

`ifdef TIMER_PRESCALER_EN
    logic [7:0] presc_q, presc_d;
    logic [7:0] prescCnt_q, prescCnt_d;

    assign tick     = (prescCnt_q == 8'd0);
    assign prescale = presc_q;

    // Prescale counter restarts from the freshly written value on START.
    always_comb begin
      presc_d    = presc_q;
      prescCnt_d = prescCnt_q;
      if (wrCtrl) presc_d = writedata[15:8];
      if (startCmd) prescCnt_d = writedata[15:8];
      else if (forceReload_q) prescCnt_d = presc_q;
      else if (run_q) prescCnt_d = tick ? presc_q : prescCnt_q - 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        presc_q    <= 8'd0;
        prescCnt_q <= 8'd0;
      end else begin
        presc_q    <= presc_d;
        prescCnt_q <= prescCnt_d;
      end
    end
`else
    assign tick     = 1'b1;
    assign prescale = 8'd0;
`endif

    // A one-shot channel parks at zero instead of reloading.
    always_comb begin
      cnt_d = cnt_q;
      if (forceReload_q) cnt_d = period_q;
      else if (run_q && tick) begin
        if (!isZero) cnt_d = cnt_q - CNT_W'(1);
        else if (ctrl_q[1]) cnt_d = period_q;
      end
    end

    always_comb begin
      run_d = run_q;
      if (startCmd) run_d = 1'b1;
      else if (stopCmd || forceReload_q || (isZero && !ctrl_q[1])) run_d = 1'b0;
    end

    always_comb begin
      to_d = to_q;
      if (wrStatus) to_d = 1'b0;
      else if (toEvent) to_d = 1'b1;
    end

    always_comb begin
      period_d = wrPeriod ? writedata[CNT_W-1:0] : period_q;
      ctrl_d   = wrCtrl ? writedata[3:0] : ctrl_q;
      snap_d   = wrSnap ? cnt_q : snap_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q         <= RST_VAL;
        period_q      <= RST_VAL;
        snap_q        <= '0;
        ctrl_q        <= '0;
        to_q          <= 1'b0;
        run_q         <= 1'b0;
        zeroDly_q     <= (RST_VAL == '0);
        forceReload_q <= 1'b0;
      end else begin
        cnt_q         <= cnt_d;
        period_q      <= period_d;
        snap_q        <= snap_d;
        ctrl_q        <= ctrl_d;
        to_q          <= to_d;
        run_q         <= run_d;
        zeroDly_q     <= isZero;
        forceReload_q <= wrPeriod;
      end
    end

    always_comb begin
      rdVal = '0;
      case (offset)
        OFF_STATUS:  rdVal[1:0] = {run_q, to_q};
        OFF_CONTROL: begin
          rdVal[3:0]  = ctrl_q;
          rdVal[15:8] = prescale;
        end
        OFF_PERIOD:  rdVal[CNT_W-1:0] = period_q;
        default:     rdVal[CNT_W-1:0] = snap_q;
      endcase
    end

    assign chRd[g]    = rdVal;
    assign irq_vec[g] = to_q & ctrl_q[0];
  end

  // Channel indices past NUM_CH match no entry and read back zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chSel == AW'(i)) readdata_d = chRd[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer: directed timing checks plus a randomized
// bus phase compared cycle-by-cycle against a behavioural model of the timer rules.
module tb_avalon_multi_timer;

  localparam int NCH     = 3;
  localparam int AW      = $clog2(NCH) + 2;
  localparam int RST_PER = 49999;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [AW-1:0]  address;
  logic           chipselect;
  logic           write_n;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic [NCH-1:0] irq_vec;
  logic           irq;

  int checks   = 0;
  int failures = 0;

  bit [31:0] mCnt   [NCH];
  bit [31:0] mPer   [NCH];
  bit [31:0] mSnap  [NCH];
  bit [3:0]  mCtrl  [NCH];
  bit [7:0]  mPs    [NCH];
  bit [7:0]  mPsCnt [NCH];
  bit        mTo    [NCH];
  bit        mRun   [NCH];
  bit        mWasZero [NCH];
  bit        mForce [NCH];
  bit [31:0] mRd;

  avalon_multi_timer #(
    .NUM_CH(NCH),
    .CNT_W(32),
    .RESET_PERIOD(RST_PER)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq_vec(irq_vec),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] regAddr(int ch, int off);
    return AW'(ch * 4 + off);
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      mCnt[c] = RST_PER; mPer[c] = RST_PER; mSnap[c] = 0; mCtrl[c] = 0;
      mPs[c] = 0; mPsCnt[c] = 0; mTo[c] = 0; mRun[c] = 0;
      mWasZero[c] = 0; mForce[c] = 0;
    end
    mRd = 0;
  endfunction

  function automatic bit [31:0] modelRead(bit [AW-1:0] a);
    int ch = int'(a >> 2);
    if (ch >= NCH) return 32'd0;
    case (a[1:0])
      2'd0: return {30'd0, mRun[ch], mTo[ch]};
`ifdef TIMER_PRESCALER_EN
      2'd1: return {16'd0, mPs[ch], 4'd0, mCtrl[ch]};
`else
      2'd1: return {28'd0, mCtrl[ch]};
`endif
      2'd2: return mPer[ch];
      default: return mSnap[ch];
    endcase
  endfunction

  function automatic bit [NCH-1:0] modelIrq();
    bit [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = mTo[c] && mCtrl[c][0];
    return v;
  endfunction

  // One clock of the timer rules; every decision uses the state from before the edge.
  function automatic void modelStep(bit cs, bit wr, bit [AW-1:0] a, bit [31:0] d);
    int ch  = int'(a >> 2);
    int off = int'(a[1:0]);
    mRd = modelRead(a);
    for (int c = 0; c < NCH; c++) begin
      bit w, zero, start, stop, tick;
      w     = cs && wr && (ch == c);
      zero  = (mCnt[c] == 0);
      start = w && off == 1 && d[2];
      stop  = w && off == 1 && d[3];
`ifdef TIMER_PRESCALER_EN
      tick = (mPsCnt[c] == 0);
`else
      tick = 1'b1;
`endif
      if (w && off == 3) mSnap[c] = mCnt[c];
      if (w && off == 0) mTo[c] = 0;
      else if (zero && !mWasZero[c]) mTo[c] = 1;
      mWasZero[c] = zero;
      if (start) mPsCnt[c] = d[15:8];
      else if (mForce[c]) mPsCnt[c] = mPs[c];
      else if (mRun[c]) mPsCnt[c] = tick ? mPs[c] : mPsCnt[c] - 8'd1;
      if (mForce[c]) mCnt[c] = mPer[c];
      else if (mRun[c] && tick) mCnt[c] = zero ? (mCtrl[c][1] ? mPer[c] : 32'd0) : mCnt[c] - 32'd1;
      if (start) mRun[c] = 1;
      else if (stop || mForce[c] || (zero && !mCtrl[c][1])) mRun[c] = 0;
      mForce[c] = w && off == 2;
      if (w && off == 1) begin
        mCtrl[c] = d[3:0];
        mPs[c]   = d[15:8];
      end
      if (w && off == 2) mPer[c] = d;
    end
  endfunction

  task automatic applyStimulus(input logic cs, input logic wr, input logic [AW-1:0] a,
                               input logic [31:0] d);
    chipselect = cs;
    write_n    = ~wr;
    address    = a;
    writedata  = d;
    modelStep(cs, wr, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic writeReg(input int ch, input int off, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, regAddr(ch, off), d);
  endtask

  task automatic readReg(input int ch, input int off);
    applyStimulus(1'b1, 1'b0, regAddr(ch, off), 32'd0);
  endtask

  task automatic waitIrq(input int ch, input int limit, output int n);
    n = 0;
    while (!irq_vec[ch] && n < limit) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    modelReset();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_irq_vec", 32'(irq_vec), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    readReg(0, 2);
    checkOutput("ch0_period_reset", readdata, 32'd49999);
    readReg(0, 0);
    checkOutput("ch0_status_reset", readdata, 32'd0);
    checkOutput("irq_after_reset", 32'(irq), 32'd0);

    // Continuous channel: first timeout 10 cycles after START, then every 10.
    writeReg(1, 2, 32'd9);
    writeReg(1, 1, 32'h7);
    waitIrq(1, 40, n);
    checkOutput("ch1_first_timeout_cycles", n, 32'd10);
    checkOutput("ch1_irq_high", 32'(irq), 32'd1);
    writeReg(1, 0, 32'd0);
    checkOutput("ch1_irq_vec_cleared", 32'(irq_vec[1]), 32'd0);
    checkOutput("ch1_irq_cleared", 32'(irq), 32'd0);
    waitIrq(1, 40, n);
    checkOutput("ch1_timeout_interval", n + 1, 32'd10);

    // One-shot channel: single timeout after 5 cycles, then parks at zero.
    writeReg(2, 2, 32'd4);
    writeReg(2, 1, 32'h5);
    waitIrq(2, 40, n);
    checkOutput("ch2_oneshot_cycles", n, 32'd5);
    readReg(2, 0);
    checkOutput("ch2_status_done", readdata, 32'h1);
    idle(); idle(); idle();
    writeReg(2, 3, 32'd0);
    readReg(2, 3);
    checkOutput("ch2_counter_holds_zero", readdata, 32'd0);

    // Snapshot taken 20 cycles after START holds the pre-update count.
    writeReg(0, 2, 32'd100);
    writeReg(0, 1, 32'h6);
    repeat (19) idle();
    writeReg(0, 3, 32'd0);
    readReg(0, 3);
    checkOutput("ch0_snapshot", readdata, 32'd81);
    writeReg(0, 1, 32'hC);
    readReg(0, 0);
    checkOutput("ch0_start_beats_stop", readdata, 32'h2);
    readReg(0, 1);
    checkOutput("ch0_control_readback", readdata, 32'hC);

    // PERIOD write while running: reload and stop two cycles later.
    writeReg(0, 2, 32'd7);
    idle();
    writeReg(0, 3, 32'd0);
    readReg(0, 3);
    checkOutput("ch0_reloaded_count", readdata, 32'd7);
    readReg(0, 0);
    checkOutput("ch0_stopped_by_period", readdata, 32'd0);

    // STATUS write landing on the timeout edge wins; that event is lost.
    writeReg(1, 0, 32'd0);
    waitIrq(1, 25, n);
    checkOutput("ch1_rephase_seen", 32'(irq_vec[1]), 32'd1);
    writeReg(1, 0, 32'd0);
    repeat (8) idle();
    writeReg(1, 0, 32'd0);
    checkOutput("ch1_clear_wins", 32'(irq_vec[1]), 32'd0);
    idle();
    checkOutput("ch1_event_lost", 32'(irq_vec[1]), 32'd0);

    // Prescaled channel: interval is (PERIOD+1)*(PRESCALE+1) when enabled.
    writeReg(2, 2, 32'd3);
    writeReg(2, 1, 32'h0307);
    writeReg(2, 0, 32'd0);
    waitIrq(2, 80, n);
    checkOutput("ch2_presc_first_seen", 32'(irq_vec[2]), 32'd1);
    writeReg(2, 0, 32'd0);
    waitIrq(2, 80, n);
`ifdef TIMER_PRESCALER_EN
    checkOutput("ch2_presc_interval", n + 1, 32'd16);
    readReg(2, 1);
    checkOutput("ch2_control_readback", readdata, 32'h0307);
`else
    checkOutput("ch2_presc_interval", n + 1, 32'd4);
    readReg(2, 1);
    checkOutput("ch2_control_readback", readdata, 32'h0007);
`endif

    // Unpopulated channel index ignores writes and reads zero.
    writeReg(3, 2, 32'd5);
    readReg(3, 2);
    checkOutput("unused_ch_period", readdata, 32'd0);
    readReg(3, 0);
    checkOutput("unused_ch_status", readdata, 32'd0);

    // Asynchronous reset in the middle of counting.
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_readdata", readdata, 32'd0);
    checkOutput("midreset_irq", 32'(irq), 32'd0);
    checkOutput("midreset_irq_vec", 32'(irq_vec), 32'd0);
    modelReset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    readReg(1, 2);
    checkOutput("postreset_ch1_period", readdata, 32'd49999);
    readReg(1, 0);
    checkOutput("postreset_ch1_status", readdata, 32'd0);
    idle(); idle();
    writeReg(1, 3, 32'd0);
    readReg(1, 3);
    checkOutput("postreset_ch1_not_resumed", readdata, 32'd49999);

    // Randomized bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic          cs, wr;
      a  = AW'($urandom_range(0, (1 << AW) - 1));
      cs = ($urandom_range(0, 9) >= 4);
      wr = 1'($urandom_range(0, 1));
      case (a[1:0])
        2'd1:    d = {16'd0, 8'($urandom_range(0, 2)), 4'd0, 4'($urandom_range(0, 15))};
        2'd2:    d = $urandom_range(0, 12);
        default: d = $urandom();
      endcase
      applyStimulus(cs, wr, a, d);
      checkOutput("rand_readdata", readdata, mRd);
      checkOutput("rand_irq_vec", 32'(irq_vec), 32'(modelIrq()));
      checkOutput("rand_irq", 32'(irq), 32'(|modelIrq()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
